cim_result_reader: RTL and testbench
====================================

CIM_RESULT_READER -- requirements
Module: cim_result_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning output skid-FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter MAX_WORDS, default 64, meaning the largest legal burst length.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle request to begin a burst (driven from inference_complete).
REQ-007 base_addr  in  IntResAddr_t  first intermediate-result address; sampled on start.
REQ-008 num_words  in  $clog2(MAX_WORDS+1)  burst length; sampled on start.
REQ-009 rd_format  in  FxFormatIntRes_t  read format; sampled on start.
REQ-010 rd_data_width  in  DataWidth_t  read width; sampled on start.
REQ-011 mem_rd_en  out  1  intermediate-result memory read strobe.
REQ-012 mem_chip_en  out  1  memory chip enable; high while busy.
REQ-013 mem_addr  out  IntResAddr_t  read address.
REQ-014 mem_format  out  FxFormatIntRes_t  registered rd_format.
REQ-015 mem_data_width  out  DataWidth_t  registered rd_data_width.
REQ-016 mem_rd_data  in  CompFx_t  read data, valid exactly 1 cycle after mem_rd_en.
REQ-017 out_valid  out  1  output word valid.
REQ-018 out_ready  in  1  downstream ready.
REQ-019 out_data  out  CompFx_t  output word.
REQ-020 out_last  out  1  marks the final word of the burst.
REQ-021 busy  out  1  burst in progress.
REQ-022 done  out  1  one-cycle pulse when the burst completes.
REQ-023 checksum  out  CompFx_t  running checksum of the burst.

Function
REQ-024 The FSM SHALL have three states:
- IDLE -> READ on start with num_words > 0.
- READ -> DRAIN when the last read is issued.
- DRAIN -> IDLE on the last out_valid&&out_ready handshake.
REQ-025 start with num_words == 0 SHALL pulse done on the next cycle, issue no reads, and leave the FSM in IDLE.
REQ-026 start while busy SHALL be ignored.
REQ-027 In READ, mem_rd_en SHALL assert only when (fifo_count + inflight − pop_this_cycle) < FIFO_DEPTH.
REQ-028 Each issued read SHALL increment mem_addr by 1; the address SHALL wrap modulo the IntResAddr_t width.
REQ-029 Read data SHALL be written to the FIFO in the cycle it returns; the FIFO SHALL never overflow and SHALL never drop a word.
REQ-030 out_valid SHALL equal FIFO non-empty, and out_data SHALL be the FIFO head.
REQ-031 out_data SHALL hold stable while out_valid && !out_ready.
REQ-032 out_last SHALL be high only together with the num_words-th word.
REQ-033 With out_ready held high, first-word latency SHALL be 2 cycles after start and sustained throughput SHALL be 1 word/cycle.
REQ-034 done SHALL pulse in the cycle after the last handshake; busy SHALL fall in the same cycle.
REQ-035 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.

Reset
REQ-036 On rst, the FSM SHALL return to IDLE, FIFO pointers/count and the inflight counter SHALL clear, and any in-flight read data SHALL be discarded.
REQ-037 While rst is high, every output SHALL be 0, including mid-burst.

Configuration
REQ-038 With CIM_RESULT_READER_CHECKSUM_EN defined, checksum SHALL accumulate the modulo-2^width sum of handshaken words, clear on accepted start, and hold after done.
REQ-039 Without CIM_RESULT_READER_CHECKSUM_EN, checksum SHALL be tied to 0 and no accumulator SHALL be synthesized.

Structure
REQ-040 The ReaderState_t enum SHALL be added to the shared package, which already holds IntResAddr_t, CompFx_t, DataWidth_t and FxFormatIntRes_t.
REQ-041 The FIFO SHALL be a sub-module named cim_sync_fifo, parameterized by type and depth.

Verification
REQ-042 start, base 100, 4 words, out_ready=1 -> reads at addresses 100..103; words appear on cycles 2..5; out_last on the 4th word; done on cycle 6.
REQ-043 6 words with out_ready low for cycles 3..8 -> at most FIFO_DEPTH outstanding; order preserved; no loss.
REQ-044 num_words=0 -> done on the next cycle; mem_rd_en never asserts.
REQ-045 base_addr = max address, 3 words -> addresses max, 0, 1.
REQ-046 rst asserted on cycle 3 of an 8-word burst -> all outputs 0; a new start produces a clean burst with no stale data.
REQ-047 With CHECKSUM_EN, words 1, 2, 3, −1 -> checksum 5; without it, checksum stays 0.

Source files
------------

// File: rtl/cim_result_reader_pkg.sv
// Shared CIM types: intermediate-result address, fixed-point word, read
// format/width descriptors and the result-reader FSM state encoding.
package cim_result_reader_pkg;

  localparam int unsigned INT_RES_ADDR_W = 8;
  localparam int unsigned COMP_FX_W      = 16;

  typedef logic [INT_RES_ADDR_W-1:0] IntResAddr_t;
  typedef logic [COMP_FX_W-1:0]      CompFx_t;
  typedef logic [1:0]                DataWidth_t;

  typedef struct packed {
    logic       is_signed;
    logic [2:0] frac_bits;
  } FxFormatIntRes_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } ReaderState_t;

endpackage

// File: rtl/cim_result_reader_if.sv
// Request, memory-port and output-stream signals of the result reader.
interface cim_result_reader_if #(
  parameter int unsigned MAX_WORDS = 64
);
  import cim_result_reader_pkg::*;

  localparam int unsigned NW_W = $clog2(MAX_WORDS + 1);

  logic            start;
  IntResAddr_t     base_addr;
  logic [NW_W-1:0] num_words;
  FxFormatIntRes_t rd_format;
  DataWidth_t      rd_data_width;

  logic            mem_rd_en;
  logic            mem_chip_en;
  IntResAddr_t     mem_addr;
  FxFormatIntRes_t mem_format;
  DataWidth_t      mem_data_width;
  CompFx_t         mem_rd_data;

  logic            out_valid;
  logic            out_ready;
  CompFx_t         out_data;
  logic            out_last;
  logic            busy;
  logic            done;
  CompFx_t         checksum;

  modport master (
    input  start, base_addr, num_words, rd_format, rd_data_width,
    input  mem_rd_data, out_ready,
    output mem_rd_en, mem_chip_en, mem_addr, mem_format, mem_data_width,
    output out_valid, out_data, out_last, busy, done, checksum
  );

  modport slave (
    output start, base_addr, num_words, rd_format, rd_data_width,
    output mem_rd_data, out_ready,
    input  mem_rd_en, mem_chip_en, mem_addr, mem_format, mem_data_width,
    input  out_valid, out_data, out_last, busy, done, checksum
  );

endinterface

// File: rtl/cim_result_reader_fifo.sv
// cim_sync_fifo: synchronous skid FIFO, power-of-2 depth, head visible on rdata.
module cim_sync_fifo #(
  parameter type         T     = logic [15:0],
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  T                           wdata,
  output T                           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cim_result_reader.sv
// Burst reader: streams num_words intermediate results from memory into a
// skid FIFO. Optional running checksum under CIM_RESULT_READER_CHECKSUM_EN.
module cim_result_reader
  import cim_result_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WORDS  = 64
) (
  input logic                 clk,
  input logic                 rst,
  cim_result_reader_if.master bus
);

  localparam int unsigned NW_W   = $clog2(MAX_WORDS + 1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W  = FCNT_W + 1;

  ReaderState_t    state_q, state_n;
  IntResAddr_t     addr_q, addr_n;
  logic [NW_W-1:0] issue_left_q, issue_left_n;
  logic [NW_W-1:0] pop_cnt_q, pop_cnt_n;
  logic [NW_W-1:0] nwords_q, nwords_n;
  FxFormatIntRes_t fmt_q, fmt_n;
  DataWidth_t      dw_q, dw_n;
  logic            done_q, done_n;
  logic            rd_inflight_q;

  logic              rd_en_c;
  IntResAddr_t       rd_addr_c;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  CompFx_t           fifo_head;
  logic              credit_ok;
  logic              last_word;

  cim_sync_fifo #(
    .T     (CompFx_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_inflight_q),
    .pop   (fifo_pop),
    .wdata (bus.mem_rd_data),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_pop  = !fifo_empty && bus.out_ready;
  // Words already buffered or on their way must leave room for the next read.
  assign credit_ok = (OCC_W'(fifo_count) + OCC_W'(rd_inflight_q) - OCC_W'(fifo_pop))
                     < OCC_W'(FIFO_DEPTH);
  assign last_word = (pop_cnt_q == nwords_q - NW_W'(1));

  // Next-state and read-issue decode; the first read leaves straight from IDLE.
  always_comb begin
    state_n      = state_q;
    addr_n       = addr_q;
    issue_left_n = issue_left_q;
    pop_cnt_n    = pop_cnt_q;
    nwords_n     = nwords_q;
    fmt_n        = fmt_q;
    dw_n         = dw_q;
    done_n       = 1'b0;
    rd_en_c      = 1'b0;
    rd_addr_c    = addr_q;

    case (state_q)
      RD_IDLE: begin
        if (bus.start) begin
          fmt_n     = bus.rd_format;
          dw_n      = bus.rd_data_width;
          nwords_n  = bus.num_words;
          pop_cnt_n = '0;
          if (bus.num_words == '0) begin
            done_n = 1'b1;
          end else begin
            rd_en_c      = 1'b1;
            rd_addr_c    = bus.base_addr;
            addr_n       = bus.base_addr + INT_RES_ADDR_W'(1);
            issue_left_n = bus.num_words - NW_W'(1);
            state_n      = RD_READ;
          end
        end
      end
      RD_READ: begin
        if (issue_left_q == '0) begin
          state_n = RD_DRAIN;
        end else if (credit_ok) begin
          rd_en_c      = 1'b1;
          addr_n       = addr_q + INT_RES_ADDR_W'(1);
          issue_left_n = issue_left_q - NW_W'(1);
          if (issue_left_q == NW_W'(1)) state_n = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        state_n = RD_DRAIN;
      end
      default: state_n = RD_IDLE;
    endcase

    if (fifo_pop && (state_q != RD_IDLE)) begin
      pop_cnt_n = pop_cnt_q + NW_W'(1);
      if (last_word) begin
        state_n = RD_IDLE;
        done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RD_IDLE;
      addr_q        <= '0;
      issue_left_q  <= '0;
      pop_cnt_q     <= '0;
      nwords_q      <= '0;
      fmt_q         <= '0;
      dw_q          <= '0;
      done_q        <= 1'b0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_n;
      addr_q        <= addr_n;
      issue_left_q  <= issue_left_n;
      pop_cnt_q     <= pop_cnt_n;
      nwords_q      <= nwords_n;
      fmt_q         <= fmt_n;
      dw_q          <= dw_n;
      done_q        <= done_n;
      rd_inflight_q <= rd_en_c;
    end
  end

`ifdef CIM_RESULT_READER_CHECKSUM_EN
  CompFx_t csum_q;
  logic    start_ok;

  assign start_ok = (state_q == RD_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (rst)           csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (fifo_pop) csum_q <= csum_q + fifo_head;
  end

  assign bus.checksum = rst ? '0 : csum_q;
`else
  assign bus.checksum = '0;
`endif

  // Every output is forced low while reset is held.
  assign bus.mem_rd_en      = !rst && rd_en_c;
  assign bus.mem_chip_en    = !rst && (rd_en_c || (state_q != RD_IDLE));
  assign bus.mem_addr       = rst ? '0 : rd_addr_c;
  assign bus.mem_format     = rst ? '0 : fmt_q;
  assign bus.mem_data_width = rst ? '0 : dw_q;
  assign bus.out_valid      = !rst && !fifo_empty;
  assign bus.out_data       = rst ? '0 : fifo_head;
  assign bus.out_last       = !rst && !fifo_empty && last_word && (state_q != RD_IDLE);
  assign bus.busy           = !rst && (state_q != RD_IDLE);
  assign bus.done           = !rst && done_q;

endmodule

// File: tb/tb_cim_result_reader.sv
// Directed self-checking bench for cim_result_reader with a 1-cycle-latency memory.
module tb_cim_result_reader;
  import cim_result_reader_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cim_result_reader_if #(.MAX_WORDS(64)) bus ();

  cim_result_reader #(.FIFO_DEPTH(DEPTH), .MAX_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  CompFx_t mem_arr [256];
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_arr[bus.mem_addr];
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  IntResAddr_t rd_addr_q[$];
  int          rd_cyc_q[$];
  CompFx_t     hs_data_q[$];
  int          hs_cyc_q[$];
  logic        hs_last_q[$];
  int          done_cyc_q[$];
  logic        done_busy_q[$];
  int          max_out, valid_cycles, busy_cycles;
  logic        rst_leak, hold_viol, prev_stall;
  CompFx_t     prev_data;

  always @(negedge clk) begin
    if (rst) rst_leak = rst_leak | (|{bus.mem_rd_en, bus.mem_chip_en, bus.mem_addr,
                         bus.mem_format, bus.mem_data_width, bus.out_valid, bus.out_data,
                         bus.out_last, bus.busy, bus.done, bus.checksum});
    if (bus.mem_rd_en) begin
      rd_addr_q.push_back(bus.mem_addr);
      rd_cyc_q.push_back(cyc - t0);
    end
    if (bus.out_valid && bus.out_ready) begin
      hs_data_q.push_back(bus.out_data);
      hs_cyc_q.push_back(cyc - t0);
      hs_last_q.push_back(bus.out_last);
    end
    if (bus.done) begin
      done_cyc_q.push_back(cyc - t0);
      done_busy_q.push_back(bus.busy);
    end
    if (bus.out_valid) valid_cycles++;
    if (bus.busy) busy_cycles++;
    if (int'(rd_cyc_q.size()) - int'(hs_cyc_q.size()) > max_out)
      max_out = int'(rd_cyc_q.size()) - int'(hs_cyc_q.size());
    if (!rst && prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) hold_viol = 1'b1;
    prev_stall = !rst && bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
  end

  task automatic clear_logs();
    rd_addr_q.delete(); rd_cyc_q.delete();
    hs_data_q.delete(); hs_cyc_q.delete(); hs_last_q.delete();
    done_cyc_q.delete(); done_busy_q.delete();
    max_out = 0; valid_cycles = 0; busy_cycles = 0;
    hold_viol = 1'b0; prev_stall = 1'b0;
  endtask

  // Cycle 0 is the cycle start is high; ready is low over [lo_a, lo_b].
  task automatic run_burst(input IntResAddr_t base, input int n, input int lo_a, input int lo_b,
                           input int rst_at, input int restart_at, input int ncyc);
    @(posedge clk); #1;
    clear_logs();
    t0 = cyc;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      bus.start         = (k == 0) || (k == restart_at);
      bus.base_addr     = (k == 0) ? base : 8'd0;
      bus.num_words     = (k == 0) ? 7'(n) : 7'd5;
      bus.rd_format     = (k == 0) ? FxFormatIntRes_t'(4'hD) : FxFormatIntRes_t'(4'h2);
      bus.rd_data_width = (k == 0) ? 2'd2 : 2'd1;
      bus.out_ready     = !(k >= lo_a && k <= lo_b);
      rst               = (k == rst_at);
    end
    @(posedge clk); #1;
    bus.start = 1'b0; rst = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_leak = 1'b0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.base_addr = 8'd7; bus.num_words = 7'd4;
    repeat (3) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    tests++; if (rst_leak !== 1'b0) begin fails++; $display("FAIL reset_outputs: got nonzero output during rst, expected all 0"); end
    tests++; if (rd_addr_q.size() != 0) begin fails++; $display("FAIL reset_no_reads: got %0d reads expected 0", rd_addr_q.size()); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if ({bus.out_valid, bus.busy, bus.done, bus.mem_rd_en, bus.mem_chip_en} !== 5'b0) begin
      fails++; $display("FAIL reset_state: got %b expected 00000", {bus.out_valid, bus.busy, bus.done, bus.mem_rd_en, bus.mem_chip_en}); end
    tests++; if (bus.checksum !== 16'h0) begin fails++; $display("FAIL reset_checksum: got %0h expected 0", bus.checksum); end
  endtask

  task automatic test_basic();
    CompFx_t exp_sum;
`ifdef CIM_RESULT_READER_CHECKSUM_EN
    exp_sum = 16'h4196;
`else
    exp_sum = 16'h0;
`endif
    run_burst(8'd100, 4, -1, -1, -1, 2, 9);
    tests++; if (rd_addr_q.size() != 4) begin fails++; $display("FAIL basic_rd_count: got %0d expected 4", rd_addr_q.size()); end
    for (int i = 0; i < 4 && i < int'(rd_addr_q.size()); i++) begin
      tests++; if (rd_addr_q[i] !== IntResAddr_t'(100 + i) || rd_cyc_q[i] != i) begin
        fails++; $display("FAIL basic_rd[%0d]: got addr %0d cyc %0d expected addr %0d cyc %0d", i, rd_addr_q[i], rd_cyc_q[i], 100 + i, i); end
    end
    tests++; if (hs_data_q.size() != 4) begin fails++; $display("FAIL basic_word_count: got %0d expected 4", hs_data_q.size()); end
    for (int i = 0; i < 4 && i < int'(hs_data_q.size()); i++) begin
      tests++; if (hs_data_q[i] !== CompFx_t'(16'h1064 + i) || hs_cyc_q[i] != 2 + i || hs_last_q[i] !== (i == 3)) begin
        fails++; $display("FAIL basic_word[%0d]: got %0h cyc %0d last %b expected %0h cyc %0d last %b",
                          i, hs_data_q[i], hs_cyc_q[i], hs_last_q[i], 16'h1064 + i, 2 + i, (i == 3)); end
    end
    tests++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != 6 || done_busy_q[0] !== 1'b0) begin
      fails++; $display("FAIL basic_done: got %0d pulses first cyc %0d expected 1 pulse cyc 6 busy 0",
                        done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1); end
    tests++; if (bus.mem_format !== FxFormatIntRes_t'(4'hD) || bus.mem_data_width !== 2'd2) begin
      fails++; $display("FAIL basic_format: got %0h/%0d expected d/2", bus.mem_format, bus.mem_data_width); end
    tests++; if (bus.checksum !== exp_sum) begin fails++; $display("FAIL basic_checksum: got %0h expected %0h", bus.checksum, exp_sum); end
  endtask

  task automatic test_stall();
    int exp_cyc [6] = '{2, 9, 10, 11, 12, 13};
    run_burst(8'd20, 6, 3, 8, -1, -1, 18);
    tests++; if (rd_addr_q.size() != 6) begin fails++; $display("FAIL stall_rd_count: got %0d expected 6", rd_addr_q.size()); end
    for (int i = 0; i < 6 && i < int'(rd_addr_q.size()); i++) begin
      tests++; if (rd_addr_q[i] !== IntResAddr_t'(20 + i)) begin
        fails++; $display("FAIL stall_rd[%0d]: got %0d expected %0d", i, rd_addr_q[i], 20 + i); end
    end
    tests++; if (hs_data_q.size() != 6) begin fails++; $display("FAIL stall_word_count: got %0d expected 6", hs_data_q.size()); end
    for (int i = 0; i < 6 && i < int'(hs_data_q.size()); i++) begin
      tests++; if (hs_data_q[i] !== CompFx_t'(16'h1014 + i) || hs_cyc_q[i] != exp_cyc[i] || hs_last_q[i] !== (i == 5)) begin
        fails++; $display("FAIL stall_word[%0d]: got %0h cyc %0d last %b expected %0h cyc %0d last %b",
                          i, hs_data_q[i], hs_cyc_q[i], hs_last_q[i], 16'h1014 + i, exp_cyc[i], (i == 5)); end
    end
    tests++; if (max_out != DEPTH) begin fails++; $display("FAIL stall_outstanding: got max %0d expected %0d", max_out, DEPTH); end
    tests++; if (hold_viol !== 1'b0) begin fails++; $display("FAIL stall_hold: got out_data change under backpressure expected stable"); end
    tests++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != 14) begin
      fails++; $display("FAIL stall_done: got %0d pulses first cyc %0d expected cyc 14",
                        done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1); end
  endtask

  task automatic test_checksum();
    CompFx_t exp_sum;
`ifdef CIM_RESULT_READER_CHECKSUM_EN
    exp_sum = 16'd5;
`else
    exp_sum = 16'd0;
`endif
    mem_arr[200] = 16'd1; mem_arr[201] = 16'd2; mem_arr[202] = 16'd3; mem_arr[203] = 16'hFFFF;
    run_burst(8'd200, 4, -1, -1, -1, -1, 10);
    tests++; if (hs_data_q.size() != 4) begin fails++; $display("FAIL csum_word_count: got %0d expected 4", hs_data_q.size()); end
    tests++; if (bus.checksum !== exp_sum) begin fails++; $display("FAIL csum_value: got %0h expected %0h", bus.checksum, exp_sum); end
    repeat (3) begin @(posedge clk); #1; end
    tests++; if (bus.checksum !== exp_sum) begin fails++; $display("FAIL csum_hold: got %0h expected %0h", bus.checksum, exp_sum); end
  endtask

  task automatic test_zero_len();
    run_burst(8'd50, 0, -1, -1, -1, -1, 4);
    tests++; if (rd_addr_q.size() != 0) begin fails++; $display("FAIL zero_reads: got %0d expected 0", rd_addr_q.size()); end
    tests++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != 1) begin
      fails++; $display("FAIL zero_done: got %0d pulses first cyc %0d expected cyc 1",
                        done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1); end
    tests++; if (busy_cycles != 0 || hs_data_q.size() != 0) begin
      fails++; $display("FAIL zero_idle: got busy %0d words %0d expected 0/0", busy_cycles, hs_data_q.size()); end
    tests++; if (bus.checksum !== 16'h0) begin fails++; $display("FAIL zero_csum_clear: got %0h expected 0", bus.checksum); end
  endtask

  task automatic test_wrap();
    IntResAddr_t exp_a [3] = '{8'hFF, 8'h00, 8'h01};
    run_burst(8'hFF, 3, -1, -1, -1, -1, 8);
    tests++; if (rd_addr_q.size() != 3 || hs_data_q.size() != 3) begin
      fails++; $display("FAIL wrap_count: got %0d reads %0d words expected 3/3", rd_addr_q.size(), hs_data_q.size()); end
    for (int i = 0; i < 3 && i < int'(rd_addr_q.size()) && i < int'(hs_data_q.size()); i++) begin
      tests++; if (rd_addr_q[i] !== exp_a[i] || hs_data_q[i] !== CompFx_t'(16'h1000 + exp_a[i])) begin
        fails++; $display("FAIL wrap[%0d]: got addr %0h data %0h expected addr %0h data %0h",
                          i, rd_addr_q[i], hs_data_q[i], exp_a[i], 16'h1000 + exp_a[i]); end
    end
    tests++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != 5) begin
      fails++; $display("FAIL wrap_done: got %0d pulses expected cyc 5", done_cyc_q.size()); end
  endtask

  task automatic test_reset_mid();
    rst_leak = 1'b0;
    run_burst(8'd10, 8, -1, -1, 3, -1, 4);
    tests++; if (rst_leak !== 1'b0) begin fails++; $display("FAIL rstmid_outputs: got nonzero output during rst expected all 0"); end
    tests++; if (rd_addr_q.size() != 3 || hs_data_q.size() != 1) begin
      fails++; $display("FAIL rstmid_pre: got %0d reads %0d words expected 3/1", rd_addr_q.size(), hs_data_q.size()); end
    clear_logs();
    repeat (4) begin @(posedge clk); #1; end
    tests++; if (valid_cycles != 0 || busy_cycles != 0 || rd_addr_q.size() != 0) begin
      fails++; $display("FAIL rstmid_stale: got valid %0d busy %0d reads %0d expected 0/0/0", valid_cycles, busy_cycles, rd_addr_q.size()); end
    run_burst(8'd40, 3, -1, -1, -1, -1, 8);
    tests++; if (hs_data_q.size() != 3) begin fails++; $display("FAIL rstmid_new_count: got %0d expected 3", hs_data_q.size()); end
    for (int i = 0; i < 3 && i < int'(hs_data_q.size()); i++) begin
      tests++; if (hs_data_q[i] !== CompFx_t'(16'h1028 + i) || hs_cyc_q[i] != 2 + i) begin
        fails++; $display("FAIL rstmid_new[%0d]: got %0h cyc %0d expected %0h cyc %0d", i, hs_data_q[i], hs_cyc_q[i], 16'h1028 + i, 2 + i); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_words = '0;
    bus.rd_format = '0; bus.rd_data_width = '0; bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem_arr[i] = CompFx_t'(16'h1000 + i);
    test_reset();
    test_basic();
    test_stall();
    test_checksum();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
